// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction filter, body-walk handshake,
// length/score/food bookkeeping and run/game-over control.
module snake_game_ctrl #(
   parameter int H_LOGIC_WIDTH = 5,
   parameter int V_LOGIC_WIDTH = 5,
   parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = H_LOGIC_WIDTH'(31),
   parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = V_LOGIC_WIDTH'(23),
   parameter logic [24:0] TICK_CYCLES  = 25'd2_500_000,
   parameter logic [9:0]  INIT_LEN     = 10'd3,
   parameter logic [9:0]  MAX_LEN      = 10'd200,
   parameter logic [9:0]  BODY_TIMEOUT = 10'd255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               btn,
   input  logic                     start,
   input  logic [H_LOGIC_WIDTH-1:0] head_x,
   input  logic [V_LOGIC_WIDTH-1:0] head_y,
   input  logic                     is_end,
   input  logic                     bite_self,
   output logic                     game_rst,
   output logic                     vld,
   output logic [3:0]               way,
   output logic                     pixel_done,
   output logic [9:0]               length,
   output logic [H_LOGIC_WIDTH-1:0] food_x,
   output logic [V_LOGIC_WIDTH-1:0] food_y,
   output logic [9:0]               score,
   output logic                     game_over
);

   // state   | meaning
   // S_IDLE  | waiting for start, outputs idle
   // S_INIT  | one cycle: pulse game_rst, load new-game values
   // S_WAIT  | counting the move tick
   // S_MOVE  | one cycle: vld pulse with the applied direction
   // S_BODY  | pixel_done high until is_end or watchdog expiry
   // S_CHECK | one cycle: food hit test
   // S_OVER  | game_over high until start
   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WAIT, S_MOVE, S_BODY, S_CHECK, S_OVER
   } state_t;

   localparam logic [3:0] DIR_RIGHT = 4'b1000;
   localparam logic [9:0] LFSR_SEED = 10'h2A5;
   localparam logic [H_LOGIC_WIDTH-1:0] FOOD_X0 = H_LOGIC_WIDTH'(16);
   localparam logic [V_LOGIC_WIDTH-1:0] FOOD_Y0 = V_LOGIC_WIDTH'(12);

   state_t state, state_nxt;
   logic [24:0] tick_cnt;
   logic [9:0]  wdog_cnt;
   logic [9:0]  lfsr;
   logic [3:0]  pending;
   logic        in_play, dir_ok, food_hit, tick_done, body_done;
   logic [3:0]  rev_way;
   logic [H_LOGIC_WIDTH-1:0] fx_raw, food_x_nxt;
   logic [V_LOGIC_WIDTH-1:0] fy_raw, food_y_nxt;

   always_comb begin
      state_nxt = state;
      in_play   = (state == S_WAIT) || (state == S_MOVE) ||
                  (state == S_BODY) || (state == S_CHECK);
      tick_done = (tick_cnt == TICK_CYCLES - 25'd1);
      body_done = is_end || (wdog_cnt == BODY_TIMEOUT - 10'd1);
      food_hit  = (head_x == food_x) && (head_y == food_y);
      rev_way   = {way[2], way[3], way[0], way[1]};
      dir_ok    = $onehot(btn) && (btn != rev_way);
      fx_raw    = lfsr[H_LOGIC_WIDTH-1:0];
      fy_raw    = lfsr[H_LOGIC_WIDTH+V_LOGIC_WIDTH-1:H_LOGIC_WIDTH];
      food_x_nxt = (int'(fx_raw) > int'(H_LOGIC_MAX)) ?
                   H_LOGIC_WIDTH'(int'(fx_raw) - int'(H_LOGIC_MAX) - 1) : fx_raw;
      food_y_nxt = (int'(fy_raw) > int'(V_LOGIC_MAX)) ?
                   V_LOGIC_WIDTH'(int'(fy_raw) - int'(V_LOGIC_MAX) - 1) : fy_raw;
      case (state)
         S_IDLE:  if (start) state_nxt = S_INIT;
         S_INIT:  state_nxt = S_WAIT;
         S_WAIT:  if (tick_done) state_nxt = S_MOVE;
         S_MOVE:  state_nxt = S_BODY;
         S_BODY:  if (body_done) state_nxt = S_CHECK;
         S_CHECK: state_nxt = S_WAIT;
         S_OVER:  if (start) state_nxt = S_INIT;
         default: state_nxt = S_IDLE;
      endcase
      if (in_play && bite_self) state_nxt = S_OVER;
   end

   // Status outputs are registered from the next state so they track the state exactly.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         wdog_cnt   <= '0;
         lfsr       <= LFSR_SEED;
         pending    <= DIR_RIGHT;
         way        <= DIR_RIGHT;
         length     <= INIT_LEN;
         score      <= '0;
         food_x     <= FOOD_X0;
         food_y     <= FOOD_Y0;
         game_rst   <= 1'b0;
         vld        <= 1'b0;
         pixel_done <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_nxt;
         lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
         game_rst   <= (state_nxt == S_INIT);
         vld        <= (state_nxt == S_MOVE);
         pixel_done <= (state_nxt == S_BODY);
         game_over  <= (state_nxt == S_OVER);
         tick_cnt   <= (state == S_WAIT && state_nxt == S_WAIT) ? tick_cnt + 25'd1 : '0;
         wdog_cnt   <= (state == S_BODY && state_nxt == S_BODY) ? wdog_cnt + 10'd1 : '0;
         if (state == S_INIT) begin
            length  <= INIT_LEN;
            score   <= '0;
            way     <= DIR_RIGHT;
            pending <= DIR_RIGHT;
            food_x  <= FOOD_X0;
            food_y  <= FOOD_Y0;
         end else begin
            if (in_play && dir_ok) pending <= btn;
            if (state == S_WAIT && state_nxt == S_MOVE) way <= pending;
            if (state == S_CHECK && state_nxt == S_WAIT && food_hit) begin
               length <= (length < MAX_LEN) ? length + 10'd1 : MAX_LEN;
               score  <= (score != 10'h3FF) ? score + 10'd1 : score;
               food_x <= food_x_nxt;
               food_y <= food_y_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl with a short tick and watchdog.
module tb_snake_game_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, is_end, bite_self;
   logic [3:0] btn;
   logic [4:0] head_x, head_y;
   logic       game_rst, vld, pixel_done, game_over;
   logic [3:0] way;
   logic [9:0] length, score;
   logic [4:0] food_x, food_y;

   snake_game_ctrl #(
      .TICK_CYCLES(25'd16),
      .BODY_TIMEOUT(10'd20)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .start(start),
      .head_x(head_x), .head_y(head_y), .is_end(is_end), .bite_self(bite_self),
      .game_rst(game_rst), .vld(vld), .way(way), .pixel_done(pixel_done),
      .length(length), .food_x(food_x), .food_y(food_y), .score(score),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int grst_cnt = 0, vld_cnt = 0, overlap_cnt = 0;
   int pd_run = 0, last_pd_len = 0;
   int end_delay = 5;

   // Monitor plus mover model: is_end raised end_delay cycles after pixel_done rises.
   always @(negedge clk) begin
      if (game_rst) grst_cnt++;
      if (vld) vld_cnt++;
      if (vld && pixel_done) overlap_cnt++;
      if (pixel_done) pd_run++;
      else begin
         if (pd_run != 0) last_pd_len = pd_run;
         pd_run = 0;
      end
      is_end = (end_delay >= 0) && pixel_done && (pd_run == end_delay + 1);
   end

   typedef struct {
      logic [3:0] b0, b1, b2;
      logic [3:0] exp_way;
   } dir_vec_t;

   dir_vec_t   vecs[8];
   logic [3:0] exp_q[$];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic next_vld(input int budget, output int c);
      c = 0;
      do begin
         step();
         c++;
      end while (!vld && c < budget);
      if (!vld) begin
         n_vec++;
         n_err++;
         $display("FAIL vld_timeout: no vld within %0d cycles", budget);
      end
   endtask

   initial begin
      int c, g0, v0;
      logic [3:0] ew;
      int exp_len, exp_score;

      vecs[0] = '{4'b0100, 4'b0110, 4'b0010, 4'b0010};
      vecs[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
      vecs[2] = '{4'b1000, 4'b0100, 4'b0000, 4'b0100};
      vecs[3] = '{4'b1000, 4'b0011, 4'b0000, 4'b0100};
      vecs[4] = '{4'b0001, 4'b1111, 4'b0000, 4'b0001};
      vecs[5] = '{4'b0010, 4'b1000, 4'b0000, 4'b1000};
      vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
      vecs[7] = '{4'b0001, 4'b0010, 4'b0000, 4'b0010};

      rst = 1'b0; start = 1'b0; btn = 4'b0000; bite_self = 1'b0;
      head_x = 5'd0; head_y = 5'd31;
      step(); step();
      check("rst_game_rst", game_rst, 0);
      check("rst_vld", vld, 0);
      check("rst_pixel_done", pixel_done, 0);
      check("rst_game_over", game_over, 0);
      check("rst_way", way, 4'b1000);
      check("rst_length", length, 3);
      check("rst_score", score, 0);
      check("rst_food_x", food_x, 16);
      check("rst_food_y", food_y, 12);

      // Start and first move latency
      rst = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_game_rst", game_rst, 1);
      next_vld(100, c);
      check("first_vld_latency", c, 17);
      check("game_rst_pulses", grst_cnt, 1);
      check("first_way", way, 4'b1000);
      check("first_length", length, 3);

      // Direction filter table, one move period per vector
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(vecs[i].exp_way);
         btn = vecs[i].b0; step(); step();
         btn = vecs[i].b1; step(); step();
         btn = vecs[i].b2; step(); step();
         btn = 4'b0000;
         next_vld(100, c);
         ew = exp_q.pop_front();
         check("dir_way", way, ew);
         check("move_period", c + 6, 24);
         if (i == 0) check("pd_len_handshake", last_pd_len, 6);
      end

      // Food hit
      head_x = 5'd16; head_y = 5'd12;
      next_vld(100, c);
      head_x = 5'd0; head_y = 5'd31;
      check("hit_length", length, 4);
      check("hit_score", score, 1);
      check("hit_food_moved", (food_x != 5'd16) || (food_y != 5'd12), 1);
      check("hit_food_y_range", food_y <= 5'd23, 1);

      // Self-bite during BODY
      step();
      check("bite_in_body", pixel_done, 1);
      bite_self = 1'b1;
      step();
      bite_self = 1'b0;
      check("bite_game_over", game_over, 1);
      v0 = vld_cnt;
      repeat (60) step();
      check("over_no_vld", vld_cnt, v0);
      check("over_held", game_over, 1);
      g0 = grst_cnt;
      start = 1'b1;
      step();
      check("restart_game_rst", game_rst, 1);
      repeat (5) step();
      start = 1'b0;
      check("restart_single_init", grst_cnt - g0, 1);
      check("restart_length", length, 3);
      check("restart_score", score, 0);
      check("restart_over_low", game_over, 0);

      // Watchdog: no is_end
      end_delay = -1;
      next_vld(100, c);
      next_vld(100, c);
      check("wdog_period", c, 38);
      check("wdog_pd_len", last_pd_len, 20);

      // Length saturation over 198 hits
      end_delay = 0;
      exp_len = 3;
      exp_score = 0;
      for (int i = 0; i < 198; i++) begin
         head_x = food_x; head_y = food_y;
         next_vld(60, c);
         exp_len = (exp_len + 1 > 200) ? 200 : exp_len + 1;
         exp_score++;
         check("sat_length", length, exp_len);
      end
      head_x = 5'd0; head_y = 5'd31;
      check("sat_length_final", length, 200);
      check("sat_score_final", score, exp_score);
      check("no_vld_pd_overlap", overlap_cnt, 0);

      // Mid-game reset: back to IDLE without a game_rst pulse
      g0 = grst_cnt;
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("midrst_length", length, 3);
      check("midrst_score", score, 0);
      check("midrst_way", way, 4'b1000);
      check("midrst_food_x", food_x, 16);
      check("midrst_food_y", food_y, 12);
      v0 = vld_cnt;
      repeat (30) step();
      check("midrst_idle_no_vld", vld_cnt, v0);
      check("midrst_no_game_rst", grst_cnt, g0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
